// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control. Arbitrates between a branch
// redirect, a load-use stall, ID-stage redirects (return, jump, call) and
// sequential fetch. It drives the PC source select, the write enables and the
// flush lines, and keeps the redirect and stall counters.
// Optional return-address stack: define FETCH_SEQ_RAS_EN to enable it.
module fetch_sequencer #(
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_req,
  input  logic        jump_req,
  input  logic        call_req,
  input  logic [15:0] call_link,
  input  logic        ret_req,
  input  logic [15:0] ret_addr,
  output logic [1:0]  pc_src,
  output logic [15:0] return_address,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic        id_flush,
  output logic [15:0] redirect_count,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {RUN, STALL, SHADOW} state_e;

  state_e      state_q, state_d;
  logic [15:0] redirect_q, redirect_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic take_branch, take_stall, take_ret, take_jump, take_call, id_ok;

  // Resolve the priority order into one-hot decisions for this cycle
  always_comb begin
    take_branch = branch_req;
    take_stall  = !branch_req && stall;
    // In SHADOW the ID stage holds a flushed bubble, so its requests are void
    id_ok       = (state_q != SHADOW) && !branch_req && !stall;
    take_ret    = id_ok && ret_req;
    take_jump   = id_ok && !ret_req && (jump_req || call_req);
    take_call   = id_ok && !ret_req && call_req;
  end

  // Next state and control outputs; reset forces the sequential-fetch values
  always_comb begin
    state_d    = RUN;
    pc_src     = 2'b00;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    if (take_branch) begin
      state_d  = SHADOW;
      pc_src   = 2'b10;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (take_stall) begin
      state_d    = STALL;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      id_flush   = 1'b1;
    end else if (take_ret) begin
      pc_src   = 2'b11;
      if_flush = 1'b1;
    end else if (take_jump) begin
      pc_src   = 2'b01;
      if_flush = 1'b1;
    end
    if (!rst_n) begin
      pc_src     = 2'b00;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      if_flush   = 1'b0;
      id_flush   = 1'b0;
    end
  end

  // Counter next values: redirects wrap, stall cycles saturate
  always_comb begin
    redirect_d  = redirect_q;
    stall_cnt_d = stall_cnt_q;
    if (take_branch || take_ret || take_jump) begin
      redirect_d = redirect_q + 16'd1;
    end
    if (take_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // FSM state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      redirect_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redirect_q  <= redirect_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign redirect_count = redirect_q;
  assign stall_count    = stall_cnt_q;

`ifdef FETCH_SEQ_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [15:0]      ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ras_empty;

  assign top_idx   = sp_q - 1'b1;
  assign ras_empty = (cnt_q == '0);

  // Top of stack when populated, otherwise the register-file value
  always_comb begin
    return_address = ret_addr;
    if (!ras_empty) begin
      return_address = ras_q[top_idx];
    end
  end

  // Stack pointer and occupancy; the pointer wraps and occupancy saturates so
  // a push into a full stack silently replaces the oldest entry
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (take_call) begin
      sp_d = sp_q + 1'b1;
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (take_ret) begin
      if (cnt_q <= CNT_W'(1)) begin
        sp_d  = '0;
        cnt_d = '0;
      end else begin
        sp_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Stack pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage; contents need no reset because occupancy gates their use
  always_ff @(posedge clk) begin
    if (rst_n && take_call) begin
      ras_q[sp_q] <= call_link;
    end
  end
`else
  logic unused_ras;

  assign unused_ras     = ^{call_link, take_call, 16'(RAS_DEPTH)};
  assign return_address = ret_addr;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
// Works for both the default build and the FETCH_SEQ_RAS_EN build.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_req, jump_req, call_req, ret_req;
  logic [15:0] call_link, ret_addr;
  logic [1:0]  pc_src;
  logic [15:0] return_address, redirect_count, stall_count;
  logic        pc_write, ifid_write, if_flush, id_flush;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer #(.RAS_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_req     (branch_req),
    .jump_req       (jump_req),
    .call_req       (call_req),
    .call_link      (call_link),
    .ret_req        (ret_req),
    .ret_addr       (ret_addr),
    .pc_src         (pc_src),
    .return_address (return_address),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .if_flush       (if_flush),
    .id_flush       (id_flush),
    .redirect_count (redirect_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {pc_src, pc_write, ifid_write, if_flush, id_flush}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_src, pc_write, ifid_write, if_flush, id_flush}, {26'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] red, input logic [15:0] stl);
    chk({tag, "_redirect"}, {16'd0, redirect_count}, {16'd0, red});
    chk({tag, "_stall"}, {16'd0, stall_count}, {16'd0, stl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stall = 0; branch_req = 0; jump_req = 0; call_req = 0; ret_req = 0;
  endtask

  localparam logic [5:0] C_SEQ   = 6'b00_1_1_0_0;
  localparam logic [5:0] C_STALL = 6'b00_0_0_0_1;
  localparam logic [5:0] C_BR    = 6'b10_1_1_1_1;
  localparam logic [5:0] C_JMP   = 6'b01_1_1_1_0;
  localparam logic [5:0] C_RET   = 6'b11_1_1_1_0;

  logic [15:0] exp_ret [5];
  logic [15:0] exp_top;

  initial begin
`ifdef FETCH_SEQ_RAS_EN
    exp_ret = '{16'h0050, 16'h0040, 16'h0030, 16'h0020, 16'hBEEF};
    exp_top = 16'h0050;
`else
    exp_ret = '{16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    exp_top = 16'hBEEF;
`endif
    rst_n = 0; idle_in(); call_link = 16'h0; ret_addr = 16'h1234;
    #3;
    chk_ctl("reset_ctl", C_SEQ);
    chk_cnt("reset", 16'd0, 16'd0);
    chk("reset_ra", {16'd0, return_address}, 32'h1234);
    tick();
    rst_n = 1;

    // Idle
    for (int i = 0; i < 5; i++) begin
      #2 chk_ctl("idle_ctl", C_SEQ);
      tick();
    end
    chk_cnt("idle", 16'd0, 16'd0);

    // Three stall cycles
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk_ctl("stall_ctl", C_STALL);
      tick();
    end
    stall = 0;
    #2 chk_ctl("after_stall_ctl", C_SEQ);
    chk_cnt("stall3", 16'd0, 16'd3);
    tick();

    // Branch with concurrent stall, then jump in the shadow cycle
    branch_req = 1; stall = 1;
    #2 chk_ctl("branch_ctl", C_BR);
    tick();
    branch_req = 0; stall = 0; jump_req = 1;
    #2 chk_ctl("shadow_jump_ctl", C_SEQ);
    tick();
    jump_req = 0;
    chk_cnt("branch", 16'd1, 16'd3);

    // Jump held under stall, then taken
    jump_req = 1; stall = 1;
    #2 chk_ctl("jump_stalled_ctl", C_STALL);
    tick();
    stall = 0;
    #2 chk_ctl("jump_ctl", C_JMP);
    tick();
    chk_cnt("jump", 16'd2, 16'd4);

    // Decode error: ret wins
    jump_req = 1; call_req = 1; ret_req = 1; ret_addr = 16'h4321;
    #2 chk_ctl("multi_ret_ctl", C_RET);
    chk("multi_ret_ra", {16'd0, return_address}, 32'h4321);
    tick();
    idle_in();

    // Branch during SHADOW re-enters SHADOW; ret in SHADOW ignored
    branch_req = 1;
    #2 chk_ctl("br1_ctl", C_BR);
    tick();
    #2 chk_ctl("br2_ctl", C_BR);
    tick();
    branch_req = 0; ret_req = 1;
    #2 chk_ctl("shadow_ret_ctl", C_SEQ);
    tick();
    ret_req = 0;
    chk_cnt("shadow", 16'd5, 16'd4);

    // Calls then returns
    for (int i = 0; i < 5; i++) begin
      call_req = 1; call_link = 16'((i + 1) * 16'h10); ret_addr = 16'hBEEF;
      #2 chk_ctl("call_ctl", C_JMP);
      tick();
    end
    call_req = 0;
    // Return held by stall must not pop
    ret_req = 1; stall = 1;
    #2 chk_ctl("ret_stalled_ctl", C_STALL);
    chk("ret_stalled_ra", {16'd0, return_address}, {16'd0, exp_top});
    tick();
    stall = 0;
    for (int i = 0; i < 5; i++) begin
      #2 chk_ctl("ret_ctl", C_RET);
      chk("ret_ra", {16'd0, return_address}, {16'd0, exp_ret[i]});
      tick();
    end
    ret_req = 0;
    chk_cnt("ras", 16'd15, 16'd5);

    // Reset in the middle of a stall run
    stall = 1;
    tick();
    tick();
    chk_cnt("pre_reset", 16'd15, 16'd7);
    rst_n = 0; ret_addr = 16'h7777;
    #1 chk_ctl("midreset_ctl", C_SEQ);
    chk_cnt("midreset", 16'd0, 16'd0);
    chk("midreset_ra", {16'd0, return_address}, 32'h7777);
    tick();
    rst_n = 1; stall = 0; ret_req = 1;
    #2 chk_ctl("post_reset_ret_ctl", C_RET);
    chk("post_reset_ra", {16'd0, return_address}, 32'h7777);
    tick();
    ret_req = 0;
    chk_cnt("post_reset", 16'd1, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
